mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
Memory-access (M) stage of the RV32I pipeline, directly downstream of the ALU/execute stage. It latches execute results and performs load/store accesses through a req/ack data-memory port. It extracts and extends load data, and produces the M-stage forwarding bus consumed by execute. It raises M_BUSY while an access is outstanding; the top level ORs M_BUSY into the STALL of all upstream stages.

Parameters:
- DMEM_ADDR_W, 32, width of the DMEM_ADDR bus. The low DMEM_ADDR_W bits of the word-aligned address are driven.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- STALL  in  1  hold the pipeline latch (downstream back-pressure)
- A_PC  in  32  PC from execute
- A_INST  in  32  instruction from execute
- A_VALID  in  1  execute output valid
- A_REG_D  in  5  destination register
- A_REG_D_V  in  32  ALU result
- A_LOAD  in  1  instruction is a load
- A_STORE  in  1  instruction is a store
- A_FUNCT3  in  3  load/store size and sign
- A_MEM_ADDR  in  32  effective byte address
- A_STORE_DATA  in  32  rs2 value (store data)
- DMEM_REQ  out  1  access request
- DMEM_WE  out  1  1 = write
- DMEM_ADDR  out  DMEM_ADDR_W  word-aligned address
- DMEM_STRB  out  4  byte enables
- DMEM_WDATA  out  32  write data
- DMEM_RDATA  in  32  read data, valid while DMEM_ACK is high
- DMEM_ACK  in  1  access complete
- M_BUSY  out  1  access outstanding
- M_PC, M_INST  out  32 each  passed through
- M_VALID  out  1  stage result valid
- M_REG_D  out  5  destination register
- M_REG_D_V  out  32  writeback value
- M_MISALIGN  out  1  misaligned access flagged
- FWD_M_VALID  out  1  forward valid
- FWD_M_REG_D  out  5  forwarded register
- FWD_M_REG_D_V  out  32  forwarded value

Behaviour:
- Reset:
  - When RST is high at a clock edge, all latches clear to 0 and the state goes to IDLE.
  - All outputs read 0 in the cycle after reset.
  - A reset during REQ drops DMEM_REQ at that edge. The outstanding access is abandoned, and a later DMEM_ACK is ignored.
- Capture:
  - The latch loads all A_* inputs at an edge when !STALL && state != REQ.
  - Otherwise the latch holds its contents.
- Misalignment:
  - mis = (funct3[1:0]==01 && addr[0]) || (funct3[1:0]==10 && addr[1:0]!=0).
  - It is evaluated on the latched values.
- FSM states: IDLE, REQ, DONE.
  - Capture with valid && (load || store) && !mis: go to REQ.
  - Any other capture: go to IDLE.
  - REQ && DMEM_ACK: go to DONE. On a load, DMEM_RDATA is registered into rdata_q.
  - REQ with no ack: stay in REQ (any number of wait cycles).
  - DONE: stay in DONE until the next capture, then branch as on any capture.
  - DMEM_ACK outside REQ is ignored.
- Memory port:
  - DMEM_REQ = (state==REQ). It is held until ack; ack in the first REQ cycle is legal.
  - DMEM_WE = store.
  - DMEM_ADDR = {addr[31:2], 2'b00}.
  - DMEM_STRB:
    - SB: 4'b0001 << addr[1:0]
    - SH: 4'b0011 << addr[1:0]
    - SW: 4'b1111
    - loads: 4'b1111
  - DMEM_WDATA:
    - SB: {4{data[7:0]}}
    - SH: {2{data[15:0]}}
    - SW: data
- Busy: M_BUSY = (state==REQ).
- Latency: non-memory instructions spend 1 cycle in the stage. Memory instructions spend 1 + number of wait cycles to ack.
- Load extraction from rdata_q using addr[1:0]:
  - LB (000): sign-extend the selected byte.
  - LBU (100): zero-extend the selected byte.
  - LH (001): sign-extend the halfword at addr[1].
  - LHU (101): zero-extend the halfword at addr[1].
  - LW (010): word as-is.
  - Any other funct3: 0.
- Outputs:
  - M_VALID = valid && state!=REQ.
  - M_REG_D_V = extracted load data for loads, else the latched ALU result.
  - Stores, misaligned instructions and rd=x0 give M_REG_D = 0.
  - M_MISALIGN = valid && (load || store) && mis. No memory access is made and no register is written.
- Forwarding:
  - FWD_M_VALID = M_VALID && !store && !M_MISALIGN && rd != 0.
  - FWD_M_REG_D = M_REG_D; FWD_M_REG_D_V = M_REG_D_V.
  - During REQ the forward is invalid. Execute is stalled by M_BUSY, and the loaded value forwards from DONE (load-use forwarding).
- STALL in DONE: the result and forward stay valid and unchanged.

Test Plan:
- ALU op, A_REG_D=5, A_REG_D_V=0x1234, no mem -> next cycle M_VALID=1, FWD_M_VALID=1, FWD_M_REG_D_V=0x1234, DMEM_REQ=0.
- LB addr=0x103, DMEM_RDATA=0x80FF_0000, ack after 3 cycles -> DMEM_ADDR=0x100, M_BUSY high for 3 cycles, then M_REG_D_V=0xFFFF_FF80.
- LHU addr=0x202, RDATA=0xBEEF_1234, ack in first REQ cycle -> M_REG_D_V=0x0000_BEEF, one busy cycle.
- SH addr=0x302, data=0xAABB_CCDD -> DMEM_WE=1, STRB=4'b1100, WDATA=0xCCDD_CCDD, FWD_M_VALID=0.
- LW addr=0x401 -> M_MISALIGN=1, DMEM_REQ stays 0, M_REG_D=0, M_BUSY=0.
- RST asserted during REQ (no ack) -> next cycle DMEM_REQ=0, M_VALID=0, state IDLE; an ack arriving afterwards has no effect.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: latches execute results, runs load/store over a req/ack
// data-memory port, extracts load data and drives the M-stage forwarding bus.
//
// state | meaning
// IDLE  | no access outstanding; latched result (if any) is presented
// REQ   | access issued, waiting for DMEM_ACK; stage busy, result invalid
// DONE  | access finished; result presented until the next capture
module mem_access #(
  parameter int DMEM_ADDR_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   STALL,
  input  logic [31:0]            A_PC,
  input  logic [31:0]            A_INST,
  input  logic                   A_VALID,
  input  logic [4:0]             A_REG_D,
  input  logic [31:0]            A_REG_D_V,
  input  logic                   A_LOAD,
  input  logic                   A_STORE,
  input  logic [2:0]             A_FUNCT3,
  input  logic [31:0]            A_MEM_ADDR,
  input  logic [31:0]            A_STORE_DATA,
  output logic                   DMEM_REQ,
  output logic                   DMEM_WE,
  output logic [DMEM_ADDR_W-1:0] DMEM_ADDR,
  output logic [3:0]             DMEM_STRB,
  output logic [31:0]            DMEM_WDATA,
  input  logic [31:0]            DMEM_RDATA,
  input  logic                   DMEM_ACK,
  output logic                   M_BUSY,
  output logic [31:0]            M_PC,
  output logic [31:0]            M_INST,
  output logic                   M_VALID,
  output logic [4:0]             M_REG_D,
  output logic [31:0]            M_REG_D_V,
  output logic                   M_MISALIGN,
  output logic                   FWD_M_VALID,
  output logic [4:0]             FWD_M_REG_D,
  output logic [31:0]            FWD_M_REG_D_V
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, inst_q, rdv_q, addr_q, sdata_q, rdata_q;
  logic        valid_q, load_q, store_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;

  logic        capture;
  logic        mis_in, mis_q, misalign;
  logic [31:0] aligned_addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  assign capture = !STALL && (state_q != REQ);
  assign mis_in  = is_misaligned(A_FUNCT3, A_MEM_ADDR[1:0]);
  assign mis_q   = is_misaligned(funct3_q, addr_q[1:0]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      rd_q     <= '0;
      rdv_q    <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      sdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        pc_q     <= A_PC;
        inst_q   <= A_INST;
        valid_q  <= A_VALID;
        rd_q     <= A_REG_D;
        rdv_q    <= A_REG_D_V;
        load_q   <= A_LOAD;
        store_q  <= A_STORE;
        funct3_q <= A_FUNCT3;
        addr_q   <= A_MEM_ADDR;
        sdata_q  <= A_STORE_DATA;
      end
      if ((state_q == REQ) && DMEM_ACK && load_q) begin
        rdata_q <= DMEM_RDATA;
      end
    end
  end

  // The REQ decision is made on the incoming values since they are latched at this same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        if (DMEM_ACK) state_d = DONE;
      end
      default: begin
        if (capture) begin
          if (A_VALID && (A_LOAD || A_STORE) && !mis_in) state_d = REQ;
          else                                           state_d = IDLE;
        end
      end
    endcase
  end

  assign aligned_addr = {addr_q[31:2], 2'b00};
  assign DMEM_REQ     = (state_q == REQ);
  assign DMEM_WE      = store_q;
  assign DMEM_ADDR    = aligned_addr[DMEM_ADDR_W-1:0];
  assign M_BUSY       = (state_q == REQ);

  always_comb begin
    DMEM_STRB = 4'b0000;
    if (store_q) begin
      case (funct3_q[1:0])
        2'b00:   DMEM_STRB = 4'b0001 << addr_q[1:0];
        2'b01:   DMEM_STRB = 4'b0011 << addr_q[1:0];
        default: DMEM_STRB = 4'b1111;
      endcase
    end else if (load_q) begin
      DMEM_STRB = 4'b1111;
    end
  end

  always_comb begin
    DMEM_WDATA = sdata_q;
    case (funct3_q[1:0])
      2'b00:   DMEM_WDATA = {4{sdata_q[7:0]}};
      2'b01:   DMEM_WDATA = {2{sdata_q[15:0]}};
      default: DMEM_WDATA = sdata_q;
    endcase
  end

  always_comb begin
    byte_sel = rdata_q[7:0];
    case (addr_q[1:0])
      2'b00:   byte_sel = rdata_q[7:0];
      2'b01:   byte_sel = rdata_q[15:8];
      2'b10:   byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_val = 32'h0;
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      3'b010:  load_val = rdata_q;
      default: load_val = 32'h0;
    endcase
  end

  assign misalign   = valid_q && (load_q || store_q) && mis_q;
  assign M_MISALIGN = misalign;
  assign M_PC       = pc_q;
  assign M_INST     = inst_q;
  assign M_VALID    = valid_q && (state_q != REQ);
  assign M_REG_D    = (store_q || misalign) ? 5'd0 : rd_q;
  assign M_REG_D_V  = load_q ? load_val : rdv_q;

  assign FWD_M_VALID   = M_VALID && !store_q && !misalign && (rd_q != 5'd0);
  assign FWD_M_REG_D   = M_REG_D;
  assign FWD_M_REG_D_V = M_REG_D_V;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, loads/stores with varying ack
// latency, misalignment, stall hold in DONE and reset while a request is pending.
module tb_mem_access;

  logic        CLK = 1'b0;
  logic        RST, STALL;
  logic [31:0] A_PC, A_INST, A_REG_D_V, A_MEM_ADDR, A_STORE_DATA;
  logic        A_VALID, A_LOAD, A_STORE;
  logic [4:0]  A_REG_D;
  logic [2:0]  A_FUNCT3;
  logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [3:0]  DMEM_STRB;
  logic        M_BUSY, M_VALID, M_MISALIGN, FWD_M_VALID;
  logic [31:0] M_PC, M_INST, M_REG_D_V, FWD_M_REG_D_V;
  logic [4:0]  M_REG_D, FWD_M_REG_D;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_n;

  always #5 CLK = ~CLK;

  mem_access #(.DMEM_ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .A_PC(A_PC), .A_INST(A_INST), .A_VALID(A_VALID), .A_REG_D(A_REG_D),
    .A_REG_D_V(A_REG_D_V), .A_LOAD(A_LOAD), .A_STORE(A_STORE), .A_FUNCT3(A_FUNCT3),
    .A_MEM_ADDR(A_MEM_ADDR), .A_STORE_DATA(A_STORE_DATA),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_STRB(DMEM_STRB),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .M_BUSY(M_BUSY), .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID),
    .M_REG_D(M_REG_D), .M_REG_D_V(M_REG_D_V), .M_MISALIGN(M_MISALIGN),
    .FWD_M_VALID(FWD_M_VALID), .FWD_M_REG_D(FWD_M_REG_D), .FWD_M_REG_D_V(FWD_M_REG_D_V)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bubble();
    A_VALID = 1'b0; A_LOAD = 1'b0; A_STORE = 1'b0; A_REG_D = 5'd0;
    A_REG_D_V = 32'h0; A_FUNCT3 = 3'd0; A_MEM_ADDR = 32'h0; A_STORE_DATA = 32'h0;
    A_PC = 32'h0; A_INST = 32'h0;
  endtask

  // Present one instruction for a single capture edge, then return to a bubble.
  task automatic issue(input logic [4:0] rd, input logic [31:0] rdv, input logic ld,
                       input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata);
    A_VALID = 1'b1; A_REG_D = rd; A_REG_D_V = rdv; A_LOAD = ld; A_STORE = st;
    A_FUNCT3 = f3; A_MEM_ADDR = addr; A_STORE_DATA = sdata;
    A_PC = 32'h1000 + addr; A_INST = 32'h13;
    tick();
    bubble();
  endtask

  // Serve an outstanding access: ack on the wait_cycles-th busy cycle; counts busy cycles.
  task automatic serve(input int wait_cycles, input logic [31:0] rdata, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!M_BUSY) break;
      busy_cycles++;
      if (busy_cycles == wait_cycles) begin
        DMEM_ACK = 1'b1; DMEM_RDATA = rdata;
      end
      tick();
      DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
    end
    if (M_BUSY) check("serve_timeout", 32'(M_BUSY), 32'd0);
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
    bubble();
    tick(); tick();
    RST = 1'b0;
    check("rst_valid", 32'(M_VALID), 32'd0);
    check("rst_req", 32'(DMEM_REQ), 32'd0);
    check("rst_busy", 32'(M_BUSY), 32'd0);
    check("rst_fwd", 32'(FWD_M_VALID), 32'd0);
    check("rst_rdv", M_REG_D_V, 32'h0);
    check("rst_strb", 32'(DMEM_STRB), 32'h0);

    // ALU op
    issue(5'd5, 32'h1234, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    check("alu_valid", 32'(M_VALID), 32'd1);
    check("alu_fwd_v", 32'(FWD_M_VALID), 32'd1);
    check("alu_fwd_rd", 32'(FWD_M_REG_D), 32'd5);
    check("alu_fwd_val", FWD_M_REG_D_V, 32'h1234);
    check("alu_req", 32'(DMEM_REQ), 32'd0);

    // ALU op writing x0: never forwarded
    issue(5'd0, 32'h55, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    check("x0_fwd", 32'(FWD_M_VALID), 32'd0);
    check("x0_rd", 32'(M_REG_D), 32'd0);

    // LB from 0x103, ack on the third busy cycle
    issue(5'd6, 32'h0, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    check("lb_req", 32'(DMEM_REQ), 32'd1);
    check("lb_addr", DMEM_ADDR, 32'h100);
    check("lb_we", 32'(DMEM_WE), 32'd0);
    check("lb_strb", 32'(DMEM_STRB), 32'hF);
    check("lb_valid_req", 32'(M_VALID), 32'd0);
    check("lb_fwd_req", 32'(FWD_M_VALID), 32'd0);
    serve(3, 32'h80FF_0000, busy_n);
    check("lb_busy_n", 32'(busy_n), 32'd3);
    check("lb_val", M_REG_D_V, 32'hFFFF_FF80);
    check("lb_fwd_v", 32'(FWD_M_VALID), 32'd1);
    check("lb_fwd_rd", 32'(FWD_M_REG_D), 32'd6);
    check("lb_req_done", 32'(DMEM_REQ), 32'd0);

    // STALL in DONE holds the result even with a new instruction offered
    STALL = 1'b1;
    A_VALID = 1'b1; A_REG_D = 5'd9; A_REG_D_V = 32'hDEAD;
    tick();
    check("stall_val", M_REG_D_V, 32'hFFFF_FF80);
    check("stall_fwd", 32'(FWD_M_VALID), 32'd1);
    check("stall_rd", 32'(M_REG_D), 32'd6);
    STALL = 1'b0;
    bubble();

    // LHU from 0x202, ack in first REQ cycle
    issue(5'd7, 32'h0, 1'b1, 1'b0, 3'b101, 32'h202, 32'h0);
    serve(1, 32'hBEEF_1234, busy_n);
    check("lhu_busy_n", 32'(busy_n), 32'd1);
    check("lhu_val", M_REG_D_V, 32'h0000_BEEF);

    // LH from 0x600 sign-extends the low halfword
    issue(5'd10, 32'h0, 1'b1, 1'b0, 3'b001, 32'h600, 32'h0);
    serve(2, 32'h1234_8001, busy_n);
    check("lh_val", M_REG_D_V, 32'hFFFF_8001);

    // SH to 0x302
    issue(5'd8, 32'h0, 1'b0, 1'b1, 3'b001, 32'h302, 32'hAABB_CCDD);
    check("sh_we", 32'(DMEM_WE), 32'd1);
    check("sh_strb", 32'(DMEM_STRB), 32'b1100);
    check("sh_wdata", DMEM_WDATA, 32'hCCDD_CCDD);
    check("sh_addr", DMEM_ADDR, 32'h300);
    serve(1, 32'h0, busy_n);
    check("sh_valid", 32'(M_VALID), 32'd1);
    check("sh_fwd", 32'(FWD_M_VALID), 32'd0);
    check("sh_rd", 32'(M_REG_D), 32'd0);

    // SB to 0x501
    issue(5'd3, 32'h0, 1'b0, 1'b1, 3'b000, 32'h501, 32'h1234_565A);
    check("sb_strb", 32'(DMEM_STRB), 32'b0010);
    check("sb_wdata", DMEM_WDATA, 32'h5A5A_5A5A);
    serve(1, 32'h0, busy_n);

    // Misaligned LW
    issue(5'd9, 32'h0, 1'b1, 1'b0, 3'b010, 32'h401, 32'h0);
    check("mis_flag", 32'(M_MISALIGN), 32'd1);
    check("mis_req", 32'(DMEM_REQ), 32'd0);
    check("mis_busy", 32'(M_BUSY), 32'd0);
    check("mis_rd", 32'(M_REG_D), 32'd0);
    check("mis_fwd", 32'(FWD_M_VALID), 32'd0);

    // Reset while REQ is pending; a late ack must be ignored
    issue(5'd11, 32'h0, 1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    check("rreq_req", 32'(DMEM_REQ), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rreq_req_drop", 32'(DMEM_REQ), 32'd0);
    check("rreq_valid", 32'(M_VALID), 32'd0);
    check("rreq_busy", 32'(M_BUSY), 32'd0);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hCAFE_F00D;
    tick();
    DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
    check("late_ack_valid", 32'(M_VALID), 32'd0);
    check("late_ack_req", 32'(DMEM_REQ), 32'd0);
    check("late_ack_rdv", M_REG_D_V, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
